// File: rtl/filter_pkg.sv
// Shared encodings and saturation helper for the shift-coefficient IIR filter.
package filter_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS    = 2'd0,
    MODE_NOTCH_FS4 = 2'd1,
    MODE_LOWPASS1  = 2'd2,
    MODE_HIGHPASS1 = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Clamp a signed value to the range of a w-bit two's complement number (w <= 31).
  function automatic logic signed [31:0] sat(input logic signed [31:0] val, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (val > hi) return hi;
    if (val < lo) return lo;
    return val;
  endfunction

endpackage

// File: rtl/shift_iir_datapath.sv
// One channel of the shift-coefficient IIR, purely combinational.
// Evaluates in DATA_W+2 bits so every mode's intermediate sum fits before saturation.
module shift_iir_datapath
  import filter_pkg::*;
#(
  parameter int DATA_W = 20,
  parameter int K_W    = 4
) (
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] x1,
  input  logic signed [DATA_W-1:0] x2,
  input  logic signed [DATA_W-1:0] y1,
  input  logic signed [DATA_W-1:0] y2,
  input  mode_e                    mode,
  input  logic        [K_W-1:0]    k,
  output logic signed [DATA_W-1:0] y
);

  localparam int CW = DATA_W + 2;

  logic signed [CW-1:0] xe;
  logic signed [CW-1:0] x1e;
  logic signed [CW-1:0] x2e;
  logic signed [CW-1:0] y1e;
  logic signed [CW-1:0] y2e;
  logic signed [CW-1:0] acc;

  assign xe  = {{2{x[DATA_W-1]}},  x};
  assign x1e = {{2{x1[DATA_W-1]}}, x1};
  assign x2e = {{2{x2[DATA_W-1]}}, x2};
  assign y1e = {{2{y1[DATA_W-1]}}, y1};
  assign y2e = {{2{y2[DATA_W-1]}}, y2};

  always_comb begin
    acc = xe;
    case (mode)
      MODE_BYPASS:    acc = xe;
      MODE_NOTCH_FS4: acc = xe + x2e - y2e + (y2e >>> k);
      MODE_LOWPASS1:  acc = y1e + ((xe - y1e) >>> k);
      MODE_HIGHPASS1: acc = xe - x1e + y1e - (y1e >>> k);
      default:        acc = xe;
    endcase
  end

  assign y = DATA_W'(sat(32'(acc), DATA_W));

endmodule

// File: rtl/module_shift_iir_mc.sv
// Multi-channel shift-coefficient IIR: one channel per cycle, frame commits N_CH+1 cycles after the strobe edge.
// No backpressure: a strobe edge while busy is dropped and latches the sticky overrun flag.
module module_shift_iir_mc
  import filter_pkg::*;
#(
  parameter int DATA_W = 20,
  parameter int N_CH   = 2,
  parameter int K_W    = 4
) (
  input  logic                     qzt_clk,
  input  logic                     rst,
  input  logic                     clk_in,
  input  logic [1:0]               mode,
  input  logic [K_W-1:0]           k,
  input  logic [N_CH*DATA_W-1:0]   Vin,
  output logic [N_CH*DATA_W-1:0]   Vout,
  output logic                     vout_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  typedef logic signed [DATA_W-1:0] smp_t;

  state_e                  state_q, state_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic                    clk_in_old_q, clk_in_old_d;
  mode_e                   mode_q, mode_d;
  logic [K_W-1:0]          k_q, k_d;
  logic                    clr_q, clr_d;
  logic [N_CH*DATA_W-1:0]  vin_q, vin_d;
  logic [N_CH*DATA_W-1:0]  shadow_q, shadow_d;
  logic [N_CH*DATA_W-1:0]  vout_q, vout_d;
  logic                    vout_valid_q, vout_valid_d;
  logic                    busy_q, busy_d;
  logic                    overrun_q, overrun_d;
  smp_t                    x1_q [N_CH];
  smp_t                    x1_d [N_CH];
  smp_t                    x2_q [N_CH];
  smp_t                    x2_d [N_CH];
  smp_t                    y1_q [N_CH];
  smp_t                    y1_d [N_CH];
  smp_t                    y2_q [N_CH];
  smp_t                    y2_d [N_CH];

  logic strobe_edge;
  smp_t x_cur, x1_eff, x2_eff, y1_eff, y2_eff, y_cur;

  // A mode change restarts the filter: history is presented as zero for the whole frame.
  assign x_cur  = vin_q[ch_q*DATA_W +: DATA_W];
  assign x1_eff = clr_q ? '0 : x1_q[ch_q];
  assign x2_eff = clr_q ? '0 : x2_q[ch_q];
  assign y1_eff = clr_q ? '0 : y1_q[ch_q];
  assign y2_eff = clr_q ? '0 : y2_q[ch_q];

  assign strobe_edge = clk_in & ~clk_in_old_q;

  shift_iir_datapath #(
    .DATA_W (DATA_W),
    .K_W    (K_W)
  ) u_dp (
    .x    (x_cur),
    .x1   (x1_eff),
    .x2   (x2_eff),
    .y1   (y1_eff),
    .y2   (y2_eff),
    .mode (mode_q),
    .k    (k_q),
    .y    (y_cur)
  );

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    clk_in_old_d = clk_in;
    mode_d       = mode_q;
    k_d          = k_q;
    clr_d        = clr_q;
    vin_d        = vin_q;
    shadow_d     = shadow_q;
    vout_d       = vout_q;
    vout_valid_d = 1'b0;
    busy_d       = busy_q;
    overrun_d    = overrun_q;
    x1_d         = x1_q;
    x2_d         = x2_q;
    y1_d         = y1_q;
    y2_d         = y2_q;

    case (state_q)
      ST_IDLE: begin
        if (strobe_edge) begin
          vin_d   = Vin;
          mode_d  = mode_e'(mode);
          k_d     = k;
          clr_d   = (mode_e'(mode) != mode_q);
          ch_d    = '0;
          busy_d  = 1'b1;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (strobe_edge) overrun_d = 1'b1;
        shadow_d[ch_q*DATA_W +: DATA_W] = y_cur;
        x2_d[ch_q] = x1_eff;
        x1_d[ch_q] = x_cur;
        y2_d[ch_q] = y1_eff;
        y1_d[ch_q] = y_cur;
        // Last channel lands in Vout together with the rest so the frame is coherent.
        if (ch_q == LAST_CH) begin
          vout_d       = shadow_d;
          vout_valid_d = 1'b1;
          state_d      = ST_COMMIT;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      ST_COMMIT: begin
        if (strobe_edge) overrun_d = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge qzt_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ch_q         <= '0;
      clk_in_old_q <= 1'b0;
      mode_q       <= MODE_BYPASS;
      k_q          <= '0;
      clr_q        <= 1'b0;
      vin_q        <= '0;
      shadow_q     <= '0;
      vout_q       <= '0;
      vout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        x1_q[c] <= '0;
        x2_q[c] <= '0;
        y1_q[c] <= '0;
        y2_q[c] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      clk_in_old_q <= clk_in_old_d;
      mode_q       <= mode_d;
      k_q          <= k_d;
      clr_q        <= clr_d;
      vin_q        <= vin_d;
      shadow_q     <= shadow_d;
      vout_q       <= vout_d;
      vout_valid_q <= vout_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      x1_q         <= x1_d;
      x2_q         <= x2_d;
      y1_q         <= y1_d;
      y2_q         <= y2_d;
    end
  end

  assign Vout       = vout_q;
  assign vout_valid = vout_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule
